seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector with Moore output. Pattern length is 1..MAX_LEN and is selectable at runtime, so the team no longer needs one hard-coded FSM per sequence.
- Supports overlapping and non-overlapping detection, gated input sampling and a saturating match counter.
- Sits on a serial input stream; z feeds downstream control logic, match_cnt feeds status readout.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, match counter width.
- RST_PATTERN, 8'b0000_1011, pattern after reset, right-aligned (bit 0 = last bit received).
- RST_LEN, 4, pattern length after reset (1..MAX_LEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only on edges where x_valid=1.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping; read live on each valid sample.
- cfg_load  in  1  one-cycle strobe that latches pattern_in and len_in.
- pattern_in  in  MAX_LEN  new pattern, right-aligned; bit[len-1] is received first, bit[0] last.
- len_in  in  $clog2(MAX_LEN)+1  new pattern length.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  Moore match flag (registered).
- match_cnt  out  CNT_W  saturating count of detected matches.

Behaviour:
- Reset (reset_n=0, asynchronous): pattern=RST_PATTERN, len=RST_LEN, history=0, fill=0, z=0, match_cnt=0. All outputs are 0 while reset is held.
- State:
  - hist: MAX_LEN-bit shift register.
  - fill: 0..MAX_LEN, the number of valid bits currently in hist.
  - cur_pat, cur_len: the configuration registers.
- Valid sample (x_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - hit = (fill+1 >= cur_len) AND (new hist[cur_len-1:0] == cur_pat[cur_len-1:0]).
- On hit:
  - z <= 1 on the same edge, so z is visible the cycle after the completing bit. This is the 1-cycle Moore latency.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - If overlap_en=0, fill <= 0, so the next match needs cur_len fresh bits. If overlap_en=1, fill is kept.
- On a valid sample with no hit: z <= 0.
- x_valid=0: every register holds. z keeps its value, as a Moore output tied to state.
- Back-to-back hits (e.g. pattern 11 with overlap on an input of 111): z stays high on consecutive cycles and the count increments each cycle.
- cfg_load=1:
  - cur_pat <= pattern_in.
  - cur_len <= clamp(len_in, 1, MAX_LEN); 0 becomes 1, and values >MAX_LEN become MAX_LEN.
  - hist <= 0, fill <= 0, z <= 0. match_cnt is unchanged.
  - Takes priority over x_valid; a sample on the same edge is discarded.
- cnt_clr=1: match_cnt <= 0. Clear wins over a simultaneous hit, though z still asserts for that hit. cnt_clr has no effect on z, hist or fill.
- Bits of cur_pat above cur_len-1 are ignored in the compare.
- A change of overlap_en takes effect on the next valid sample only; it causes no retroactive change to fill.
- Reset asserted mid-stream: all state is lost immediately. After release the block behaves as if freshly reset, with no partial match retained.

Test Plan:
- Reset default (1011), overlap_en=1, valid stream 1,0,1,1,0,1,1 -> z=1 in the cycle after bit 4 and after bit 7, low otherwise; match_cnt=2.
- Same stream with overlap_en=0 -> only the bit-4 match fires; match_cnt=1. Then stream 1,0,1,1 -> second match; match_cnt=2.
- Gating: stream 1,0,1,1 with x_valid=0 idle cycles inserted, including after bit 4 -> z rises after bit 4 and stays 1 through the idle cycles. A subsequent valid 0 drops z.
- cfg_load with pattern_in=8'b0000_0011, len_in=2, overlap=1, then stream 1,1,1,1 -> z high for 3 consecutive cycles; match_cnt +3. Also load with len_in=0 -> cur_len=1, so each matching bit hits.
- Saturation and clear with CNT_W=2: 5 matches -> match_cnt=3. Then cnt_clr asserted on a hit edge -> match_cnt=0 and z=1. cfg_load and x_valid on the same edge -> sample dropped, hist cleared.
- Assert reset_n=0 mid-pattern (after bits 1,0,1), release, then send 1 -> no match; a full 1,0,1,1 is required for z.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
// Bundles the serial stream, configuration and status signals of the
// programmable sequence detector into one interface.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               x;
    logic               x_valid;
    logic               overlap_en;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern_in;
    logic [LEN_W-1:0]   len_in;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;

    // The stream source and configuration owner drive the inputs.
    modport master (
        output x, x_valid, overlap_en, cfg_load, pattern_in, len_in, cnt_clr,
        input  z, match_cnt
    );

    // The detector consumes the inputs and reports match status.
    modport slave (
        input  x, x_valid, overlap_en, cfg_load, pattern_in, len_in, cnt_clr,
        output z, match_cnt
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a registered (Moore)
// match flag, overlapping/non-overlapping modes and a saturating counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
    parameter int                 RST_LEN     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_detector_prog_if.slave bus
);
    localparam int               LEN_W   = $clog2(MAX_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The oldest history bit is only ever needed in the compare of the
    // current sample, so it is never stored: r_hist keeps MAX_LEN-1 bits and
    // the incoming bit completes the full MAX_LEN-bit window.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_z;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_histNext;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fillInc;
    logic [LEN_W-1:0]   w_fillNext;
    logic [LEN_W-1:0]   w_lenClamp;
    logic               w_hit;
    logic               w_sample;

    // Match evaluation on the window that includes the incoming bit.
    always_comb begin
        w_sample   = bus.x_valid && !bus.cfg_load;
        w_histNext = {r_hist, bus.x};
        w_mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_fillInc  = r_fill + LEN_W'(1);
        w_fillNext = (w_fillInc > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_fillInc;
        w_hit      = (w_fillInc >= r_len) &&
                     ((w_histNext & w_mask) == (r_pat & w_mask));
    end

    // Clamp a requested length into the legal 1..MAX_LEN range.
    always_comb begin
        w_lenClamp = bus.len_in;
        if (bus.len_in == '0) begin
            w_lenClamp = LEN_W'(1);
        end else if (bus.len_in > LEN_W'(MAX_LEN)) begin
            w_lenClamp = LEN_W'(MAX_LEN);
        end
    end

    // Configuration, history and match flag; a load restarts detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pat  <= RST_PATTERN;
            r_len  <= LEN_W'(RST_LEN);
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (bus.cfg_load) begin
            r_pat  <= bus.pattern_in;
            r_len  <= w_lenClamp;
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (bus.x_valid) begin
            r_hist <= w_histNext[MAX_LEN-2:0];
            r_z    <= w_hit;
            r_fill <= (w_hit && !bus.overlap_en) ? '0 : w_fillNext;
        end
    end

    // Saturating match counter; an explicit clear beats a coincident hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_sample && w_hit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.z         = r_z;
    assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog: a default instance and
// a second instance with a 2-bit counter share the same stimulus.
module tb_seq_detector_prog;
    logic clk;
    logic reset_n;
    int   nCompared;
    int   nMismatched;

    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) ifMain ();
    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2)) ifSat ();

    seq_detector_prog dutMain (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifMain.slave)
    );

    seq_detector_prog #(.CNT_W(2)) dutSat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifSat.slave)
    );

    assign ifSat.x          = ifMain.x;
    assign ifSat.x_valid    = ifMain.x_valid;
    assign ifSat.overlap_en = ifMain.overlap_en;
    assign ifSat.cfg_load   = ifMain.cfg_load;
    assign ifSat.pattern_in = ifMain.pattern_in;
    assign ifSat.len_in     = ifMain.len_in;
    assign ifSat.cnt_clr    = ifMain.cnt_clr;

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic sendBit(input logic b);
        ifMain.x       = b;
        ifMain.x_valid = 1'b1;
        @(posedge clk);
        #1;
        ifMain.x_valid = 1'b0;
    endtask

    task automatic idleCycle();
        ifMain.x_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len);
        ifMain.pattern_in = pat;
        ifMain.len_in     = len;
        ifMain.cfg_load   = 1'b1;
        @(posedge clk);
        #1;
        ifMain.cfg_load   = 1'b0;
    endtask

    task automatic doReset();
        ifMain.x          = 1'b0;
        ifMain.x_valid    = 1'b0;
        ifMain.cfg_load   = 1'b0;
        ifMain.cnt_clr    = 1'b0;
        ifMain.pattern_in = '0;
        ifMain.len_in     = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifMain.overlap_en = 1'b1;
        doReset();
        reset_n = 1'b0;
        #2;
        nCompared++;
        if (ifMain.z !== 1'b0 || ifMain.match_cnt !== 8'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_hold: z=%b cnt=%0d expected z=0 cnt=0", ifMain.z, ifMain.match_cnt);
        end
        nCompared++;
        if (ifSat.z !== 1'b0 || ifSat.match_cnt !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_hold_sat: z=%b cnt=%0d expected z=0 cnt=0", ifSat.z, ifSat.match_cnt);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] zExp;
        bits = 7'b1011011;
        zExp = 7'b0001001;
        ifMain.overlap_en = 1'b1;
        doReset();
        for (int k = 0; k < 7; k++) begin
            sendBit(bits[6-k]);
            nCompared++;
            if (ifMain.z !== zExp[6-k]) begin
                nMismatched++;
                $display("[TB] FAIL overlap_z bit%0d: z=%b expected %b", k + 1, ifMain.z, zExp[6-k]);
            end
        end
        nCompared++;
        if (ifMain.match_cnt !== 8'd2) begin
            nMismatched++;
            $display("[TB] FAIL overlap_cnt: cnt=%0d expected 2", ifMain.match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic [10:0] bits;
        logic [10:0] zExp;
        bits = 11'b1011011_1011;
        zExp = 11'b0001000_0001;
        ifMain.overlap_en = 1'b0;
        doReset();
        for (int k = 0; k < 11; k++) begin
            sendBit(bits[10-k]);
            nCompared++;
            if (ifMain.z !== zExp[10-k]) begin
                nMismatched++;
                $display("[TB] FAIL nonoverlap_z bit%0d: z=%b expected %b", k + 1, ifMain.z, zExp[10-k]);
            end
            if (k == 6) begin
                nCompared++;
                if (ifMain.match_cnt !== 8'd1) begin
                    nMismatched++;
                    $display("[TB] FAIL nonoverlap_cnt1: cnt=%0d expected 1", ifMain.match_cnt);
                end
            end
        end
        nCompared++;
        if (ifMain.match_cnt !== 8'd2) begin
            nMismatched++;
            $display("[TB] FAIL nonoverlap_cnt2: cnt=%0d expected 2", ifMain.match_cnt);
        end
    endtask

    task automatic test_gating();
        ifMain.overlap_en = 1'b1;
        doReset();
        sendBit(1'b1);
        idleCycle();
        sendBit(1'b0);
        sendBit(1'b1);
        idleCycle();
        nCompared++;
        if (ifMain.z !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL gating_pre: z=%b expected 0", ifMain.z);
        end
        sendBit(1'b1);
        nCompared++;
        if (ifMain.z !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL gating_hit: z=%b expected 1", ifMain.z);
        end
        for (int k = 0; k < 3; k++) begin
            idleCycle();
            nCompared++;
            if (ifMain.z !== 1'b1 || ifMain.match_cnt !== 8'd1) begin
                nMismatched++;
                $display("[TB] FAIL gating_hold%0d: z=%b cnt=%0d expected z=1 cnt=1", k, ifMain.z, ifMain.match_cnt);
            end
        end
        sendBit(1'b0);
        nCompared++;
        if (ifMain.z !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL gating_drop: z=%b expected 0", ifMain.z);
        end
    endtask

    task automatic test_cfg_load();
        logic [3:0] zExp;
        logic [2:0] bits1;
        logic [2:0] z1;
        logic [7:0] bits8;
        ifMain.overlap_en = 1'b1;
        doReset();
        loadCfg(8'b0000_0011, 4'd2);
        nCompared++;
        if (ifMain.z !== 1'b0 || ifMain.match_cnt !== 8'd0) begin
            nMismatched++;
            $display("[TB] FAIL cfg_after_load: z=%b cnt=%0d expected z=0 cnt=0", ifMain.z, ifMain.match_cnt);
        end
        zExp = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            sendBit(1'b1);
            nCompared++;
            if (ifMain.z !== zExp[3-k]) begin
                nMismatched++;
                $display("[TB] FAIL back_to_back_z bit%0d: z=%b expected %b", k + 1, ifMain.z, zExp[3-k]);
            end
        end
        nCompared++;
        if (ifMain.match_cnt !== 8'd3) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back_cnt: cnt=%0d expected 3", ifMain.match_cnt);
        end
        // Zero length clamps to 1: every '1' bit is a match.
        loadCfg(8'b0000_0001, 4'd0);
        bits1 = 3'b101;
        z1    = 3'b101;
        for (int k = 0; k < 3; k++) begin
            sendBit(bits1[2-k]);
            nCompared++;
            if (ifMain.z !== z1[2-k]) begin
                nMismatched++;
                $display("[TB] FAIL len0_z bit%0d: z=%b expected %b", k + 1, ifMain.z, z1[2-k]);
            end
        end
        nCompared++;
        if (ifMain.match_cnt !== 8'd5) begin
            nMismatched++;
            $display("[TB] FAIL len0_cnt: cnt=%0d expected 5", ifMain.match_cnt);
        end
        // Upper pattern bits beyond the length must be ignored.
        loadCfg(8'b1111_0110, 4'd3);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        nCompared++;
        if (ifMain.z !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL upper_bits_ignored: z=%b expected 1", ifMain.z);
        end
        // Oversized length clamps to 8: only the full 8-bit pattern hits.
        loadCfg(8'hA5, 4'd15);
        bits8 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            sendBit(bits8[7-k]);
            nCompared++;
            if (ifMain.z !== (k == 7)) begin
                nMismatched++;
                $display("[TB] FAIL len_clamp_z bit%0d: z=%b expected %b", k + 1, ifMain.z, (k == 7));
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] cntExp [5];
        cntExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        ifMain.overlap_en = 1'b1;
        doReset();
        loadCfg(8'b0000_0001, 4'd1);
        for (int k = 0; k < 5; k++) begin
            sendBit(1'b1);
            nCompared++;
            if (ifSat.z !== 1'b1 || ifSat.match_cnt !== cntExp[k]) begin
                nMismatched++;
                $display("[TB] FAIL sat_cnt hit%0d: z=%b cnt=%0d expected z=1 cnt=%0d", k + 1, ifSat.z, ifSat.match_cnt, cntExp[k]);
            end
        end
        // Clear on a hit edge: z still asserts, counter goes to zero.
        ifMain.cnt_clr = 1'b1;
        sendBit(1'b1);
        ifMain.cnt_clr = 1'b0;
        nCompared++;
        if (ifSat.z !== 1'b1 || ifSat.match_cnt !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL clr_on_hit: z=%b cnt=%0d expected z=1 cnt=0", ifSat.z, ifSat.match_cnt);
        end
        // Load and sample on the same edge: the sample is discarded.
        ifMain.x       = 1'b1;
        ifMain.x_valid = 1'b1;
        loadCfg(8'b0000_0011, 4'd2);
        ifMain.x_valid = 1'b0;
        nCompared++;
        if (ifSat.z !== 1'b0 || ifSat.match_cnt !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL load_vs_sample: z=%b cnt=%0d expected z=0 cnt=0", ifSat.z, ifSat.match_cnt);
        end
        sendBit(1'b1);
        nCompared++;
        if (ifSat.z !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sample_dropped: z=%b expected 0", ifSat.z);
        end
        sendBit(1'b1);
        nCompared++;
        if (ifSat.z !== 1'b1 || ifSat.match_cnt !== 2'd1) begin
            nMismatched++;
            $display("[TB] FAIL after_drop_hit: z=%b cnt=%0d expected z=1 cnt=1", ifSat.z, ifSat.match_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] zExp;
        zExp = 4'b0001;
        ifMain.overlap_en = 1'b1;
        doReset();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        sendBit(1'b1);
        nCompared++;
        if (ifMain.z !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_no_partial: z=%b expected 0", ifMain.z);
        end
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        nCompared++;
        if (ifMain.z !== zExp[0] || ifMain.match_cnt !== 8'd1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_full: z=%b cnt=%0d expected z=1 cnt=1", ifMain.z, ifMain.match_cnt);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset_n     = 1'b0;
        ifMain.x          = 1'b0;
        ifMain.x_valid    = 1'b0;
        ifMain.overlap_en = 1'b1;
        ifMain.cfg_load   = 1'b0;
        ifMain.pattern_in = '0;
        ifMain.len_in     = '0;
        ifMain.cnt_clr    = 1'b0;
        #1;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gating();
        test_cfg_load();
        test_saturation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
